// File: rtl/serial_bubble_sorter_if.sv
// Word-stream handshake bundle for the serial bubble sorter: one input
// channel feeding the batch, one output channel draining it in sorted order.
interface serial_bubble_sorter_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/serial_bubble_sorter.sv
// Loads N unsigned words, bubble-sorts them in place with one compare-swap per
// clock, then streams them out ascending with the largest word flagged last.
module serial_bubble_sorter #(
   parameter int W = 8,
   parameter int N = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_bubble_sorter_if.slave bus,
   output logic                  busy
);
   localparam int AW = $clog2(N);
   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
   localparam logic [AW-1:0] PASS_LAST = AW'(N - 2);

   typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic [AW-1:0] pass, pos;
   logic [W-1:0]  mem [N];

   logic [AW-1:0] cidx, pos_b, pos_end;
   logic          load_fire, drain_fire, pass_done, sort_done, swap;

   assign cidx       = cnt[AW-1:0];
   assign pos_b      = pos + 1'b1;
   // Each pass bubbles the largest remaining word to the top, so passes shrink.
   assign pos_end    = PASS_LAST - pass;
   assign load_fire  = (state == LOAD) && bus.in_valid;
   assign drain_fire = (state == DRAIN) && bus.out_ready;
   assign pass_done  = (pos == pos_end);
   assign sort_done  = pass_done && (pass == PASS_LAST);
   assign swap       = mem[pos] > mem[pos_b];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n      = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_data  = '0;
      busy          = 1'b0;
      case (state)
         IDLE: state_n = LOAD;
         LOAD: begin
            bus.in_ready = 1'b1;
            if (load_fire && (cnt == CNT_LAST)) state_n = SORT;
         end
         SORT: begin
            busy = 1'b1;
            if (sort_done) state_n = DRAIN;
         end
         DRAIN: begin
            busy          = 1'b1;
            bus.out_valid = 1'b1;
            bus.out_data  = mem[cidx];
            bus.out_last  = (cnt == CNT_LAST);
            if (drain_fire && (cnt == CNT_LAST)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         pass <= '0;
         pos  <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt  <= '0;
               pass <= '0;
               pos  <= '0;
            end
            LOAD:
               if (load_fire) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            SORT:
               if (pass_done) begin
                  pos  <= '0;
                  pass <= sort_done ? '0 : pass + 1'b1;
               end else begin
                  pos <= pos_b;
               end
            DRAIN:
               if (drain_fire) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            default: ;
         endcase
      end
   end

   // Storage carries no reset: contents are only ever read after a full load.
   always_ff @(posedge clk) begin
      if (load_fire) begin
         mem[cidx] <= bus.in_data;
      end else if ((state == SORT) && swap) begin
         mem[pos]   <= mem[pos_b];
         mem[pos_b] <= mem[pos];
      end
   end
endmodule

// File: tb/tb_serial_bubble_sorter.sv
// Randomized bench for serial_bubble_sorter: an N=3 and an N=8 instance driven
// from a cycle-level reference that sorts each batch and predicts every output.
module tb_serial_bubble_sorter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   serial_bubble_sorter_if #(.W(8)) if3 ();
   serial_bubble_sorter_if #(.W(8)) if8 ();
   logic busy3, busy8;

   serial_bubble_sorter #(.W(8), .N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(if3.slave), .busy(busy3));
   serial_bubble_sorter #(.W(8), .N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(if8.slave), .busy(busy8));

   logic       in_valid_s  [2];
   logic [7:0] in_data_s   [2];
   logic       out_ready_s [2];

   assign if3.in_valid  = in_valid_s[0];
   assign if3.in_data   = in_data_s[0];
   assign if3.out_ready = out_ready_s[0];
   assign if8.in_valid  = in_valid_s[1];
   assign if8.in_data   = in_data_s[1];
   assign if8.out_ready = out_ready_s[1];

   int         checks = 0;
   int         errors = 0;
   logic [7:0] stim_q [$];
   bit         in_tab  [6];
   bit         out_tab [6];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic sample(input int d, output logic rdy, output logic vld,
                         output logic lst, output logic bsy, output logic [7:0] dat);
      if (d == 0) begin
         rdy = if3.in_ready; vld = if3.out_valid; lst = if3.out_last;
         bsy = busy3; dat = if3.out_data;
      end else begin
         rdy = if8.in_ready; vld = if8.out_valid; lst = if8.out_last;
         bsy = busy8; dat = if8.out_data;
      end
   endtask

   task automatic check_reset_values(input int d);
      logic rdy, vld, lst, bsy;
      logic [7:0] dat;
      sample(d, rdy, vld, lst, bsy, dat);
      chk("rst_in_ready", rdy, 0);
      chk("rst_out_valid", vld, 0);
      chk("rst_out_last", lst, 0);
      chk("rst_busy", bsy, 0);
      chk("rst_out_data", dat, 0);
   endtask

   task automatic do_abort(input int d);
      #2 rst_n = 1'b0;
      #1 check_reset_values(d);
      in_valid_s[d] = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic fill_random(input int n);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
   endtask

   // in_mode/out_mode: 0 always asserted, 1 random, 2 fixed six-entry table.
   // abort: 0 none, 1 reset after one compare, 2 reset after one output.
   task automatic run_batch(input int d, input int n, input int in_mode, input int out_mode,
                            input bit hold, input bit chk_idle, input int abort);
      logic [7:0] exp_q [$];
      logic rdy, vld, lst, bsy;
      logic [7:0] dat;
      int sent, recv, cyc, acc_cyc, k, in_i, out_i;
      bit v, r;
      exp_q = stim_q;
      exp_q.sort();
      k = n * (n - 1) / 2;
      if (chk_idle) begin
         @(negedge clk);
         sample(d, rdy, vld, lst, bsy, dat);
         chk("idle_in_ready", rdy, 0);
         chk("idle_out_valid", vld, 0);
         chk("idle_busy", bsy, 0);
         in_valid_s[d]  = 1'b1;
         in_data_s[d]   = 8'($urandom);
         out_ready_s[d] = ($urandom_range(0, 1) == 1);
      end
      sent = 0; recv = 0; cyc = 0; acc_cyc = -1000; in_i = 0; out_i = 0;
      while (recv < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         sample(d, rdy, vld, lst, bsy, dat);
         if (sent < n) begin
            chk("load_in_ready", rdy, 1);
            chk("load_out_valid", vld, 0);
            chk("load_busy", bsy, 0);
            case (in_mode)
               0:       v = 1'b1;
               1:       v = ($urandom_range(0, 1) == 1);
               default: v = in_tab[in_i % 6];
            endcase
            in_i++;
            v = v | hold;
            in_valid_s[d]  = v;
            in_data_s[d]   = v ? stim_q[sent] : 8'($urandom);
            out_ready_s[d] = ($urandom_range(0, 1) == 1);
            if (v) begin
               sent++;
               if (sent == n) acc_cyc = cyc;
            end
         end else if (cyc <= acc_cyc + k) begin
            chk("sort_in_ready", rdy, 0);
            chk("sort_out_valid", vld, 0);
            chk("sort_busy", bsy, 1);
            in_valid_s[d]  = hold | ($urandom_range(0, 1) == 1);
            in_data_s[d]   = 8'($urandom);
            out_ready_s[d] = ($urandom_range(0, 1) == 1);
            if (abort == 1 && cyc == acc_cyc + 2) begin
               do_abort(d);
               return;
            end
         end else begin
            chk("drain_in_ready", rdy, 0);
            chk("drain_out_valid", vld, 1);
            chk("drain_busy", bsy, 1);
            chk("drain_out_data", dat, exp_q[recv]);
            chk("drain_out_last", lst, (recv == n - 1));
            if (abort == 2 && recv == 1) begin
               do_abort(d);
               return;
            end
            case (out_mode)
               0:       r = 1'b1;
               1:       r = ($urandom_range(0, 1) == 1);
               default: r = out_tab[out_i % 6];
            endcase
            out_i++;
            out_ready_s[d] = r;
            in_valid_s[d]  = hold | ($urandom_range(0, 1) == 1);
            in_data_s[d]   = 8'($urandom);
            if (r) recv++;
         end
      end
      if (recv < n) chk("drain_timeout", recv, n);
      in_valid_s[d] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      in_tab  = '{1, 0, 0, 1, 0, 1};
      out_tab = '{0, 1, 0, 0, 1, 1};
      for (int i = 0; i < 2; i++) begin
         in_valid_s[i] = 1'b0; in_data_s[i] = 8'h00; out_ready_s[i] = 1'b0;
      end
      rst_n = 1'b0;
      #12;
      check_reset_values(0);
      check_reset_values(1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // N=8: reverse order, already sorted, then a random batch with stalls.
      stim_q = '{8'd200, 8'd150, 8'd90, 8'd60, 8'd30, 8'd10, 8'd5, 8'd0};
      run_batch(1, 8, 0, 0, 0, 1, 0);
      stim_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      run_batch(1, 8, 0, 0, 0, 1, 0);
      fill_random(8);
      run_batch(1, 8, 1, 1, 0, 1, 0);

      // N=3: basic, duplicates, extremes, fixed gap/stall patterns, held valid.
      stim_q = '{8'd2, 8'd4, 8'd1};
      run_batch(0, 3, 0, 0, 0, 0, 0);
      stim_q = '{8'd7, 8'd3, 8'd7};
      run_batch(0, 3, 0, 0, 0, 1, 0);
      stim_q = '{8'd255, 8'd0, 8'd255};
      run_batch(0, 3, 0, 0, 0, 1, 0);
      fill_random(3);
      run_batch(0, 3, 2, 2, 0, 1, 0);
      fill_random(3);
      run_batch(0, 3, 0, 0, 1, 1, 0);
      for (int t = 0; t < 6; t++) begin
         fill_random(3);
         run_batch(0, 3, $urandom_range(0, 2), $urandom_range(0, 2), 0, 1, 0);
      end

      // Asynchronous reset mid-sort and mid-drain, each followed by 9,8,7.
      fill_random(3);
      run_batch(0, 3, 0, 0, 0, 1, 1);
      stim_q = '{8'd9, 8'd8, 8'd7};
      run_batch(0, 3, 0, 0, 0, 1, 0);
      fill_random(3);
      run_batch(0, 3, 0, 0, 0, 1, 2);
      stim_q = '{8'd9, 8'd8, 8'd7};
      run_batch(0, 3, 0, 0, 0, 1, 0);

      fill_random(8);
      run_batch(1, 8, 1, 2, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
